// File: rtl/dds_note_pkg.sv
// rtl/dds_note_pkg.sv - shared semitone table, defaults and FSM state type for dds2note_conv
package dds_note_pkg;

    localparam int OCT_MAX_DEF  = 10;
    localparam int NOTE_MAX_DEF = 127;

    // Top-octave increments for notes 120..131; lower octaves are right shifts of these.
    localparam logic [31:0] NOTE_TBL [12] = '{
        32'd749115431,  32'd793660157,  32'd840853652,  32'd890853736,
        32'd943826673,  32'd999949534,  32'd1059409633, 32'd1122405432,
        32'd1189147128, 32'd1259857503, 32'd1334772387, 32'd1414142084
    };

    localparam logic [31:0] TBL_C0 = NOTE_TBL[0];

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        NORM,
        SCAN,
        FIN
    } state_t;

    function automatic logic [31:0] tbl_word(input logic [3:0] a);
        logic [31:0] v;
        case (a)
            4'd0:    v = NOTE_TBL[0];
            4'd1:    v = NOTE_TBL[1];
            4'd2:    v = NOTE_TBL[2];
            4'd3:    v = NOTE_TBL[3];
            4'd4:    v = NOTE_TBL[4];
            4'd5:    v = NOTE_TBL[5];
            4'd6:    v = NOTE_TBL[6];
            4'd7:    v = NOTE_TBL[7];
            4'd8:    v = NOTE_TBL[8];
            4'd9:    v = NOTE_TBL[9];
            4'd10:   v = NOTE_TBL[10];
            4'd11:   v = NOTE_TBL[11];
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dds2note_conv_if.sv
// rtl/dds2note_conv_if.sv - request/result bundle between a converter client and dds2note_conv
interface dds2note_conv_if;
    logic        start;
    logic [31:0] adder;
    logic        busy;
    logic        done;
    logic [6:0]  note;
    logic        under;
    logic        over;

    modport master (
        output start, adder,
        input  busy, done, note, under, over
    );

    modport slave (
        input  start, adder,
        output busy, done, note, under, over
    );
endinterface

// File: rtl/note2dds_rom.sv
// rtl/note2dds_rom.sv - 16x32 semitone increment ROM, one-cycle registered read
module note2dds_rom
    import dds_note_pkg::*;
(
    input  logic        clk,
    input  logic [3:0]  addr,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        q <= tbl_word(addr);
    end

endmodule

// File: rtl/dds2note_conv.sv
// rtl/dds2note_conv.sv - DDS phase increment to MIDI note (floor match), iterative normalise and scan
module dds2note_conv
    import dds_note_pkg::*;
#(
    parameter int OCT_MAX  = OCT_MAX_DEF,
    parameter int NOTE_MAX = NOTE_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    dds2note_conv_if.slave   bus
);

    localparam logic [32:0] TWO_C0 = {TBL_C0, 1'b0};

    state_t      state;
    state_t      state_nxt;
    logic [32:0] w;
    logic [3:0]  s;
    logic [3:0]  k;
    logic [6:0]  note_r;
    logic        under_r;
    logic        over_r;
    logic [3:0]  rom_addr;
    logic [31:0] rom_q;

    logic [32:0] low_mask;
    logic [32:0] c0_cut;
    logic [32:0] tk_cut;
    logic        w_ge_2c0;
    logic        w_ge_c0;
    logic        hit;
    logic        s_at_max;
    logic [3:0]  oct;
    logic [7:0]  oct8;
    logic [7:0]  n_calc;
    logic        n_over;

    note2dds_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .q    (rom_q)
    );

    // The ROM output always holds NOTE_TBL[k] while scanning, so fetch k-1 ahead.
    assign rom_addr = (state == SCAN) ? (k - 4'd1) : k;

    // W carries s zero LSBs after shifting; compare against the table truncated the same
    // way so the result matches the floor of the right-shifted per-octave increments.
    assign low_mask = ~((33'd1 << s) - 33'd1);
    assign c0_cut   = {1'b0, TBL_C0} & low_mask;
    assign tk_cut   = {1'b0, rom_q} & low_mask;
    assign w_ge_2c0 = (w >= TWO_C0);
    assign w_ge_c0  = (w >= c0_cut);
    assign hit      = (w >= tk_cut);
    assign s_at_max = (s == OCT_MAX[3:0]);

    assign oct    = OCT_MAX[3:0] - s;
    assign oct8   = {4'b0000, oct};
    assign n_calc = (oct8 << 3) + (oct8 << 2) + {4'b0000, k};
    assign n_over = (n_calc > NOTE_MAX[7:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CHECK;
            CHECK:   state_nxt = w_ge_2c0 ? FIN : NORM;
            NORM: begin
                if (w_ge_c0) begin
                    state_nxt = SCAN;
                end else if (s_at_max) begin
                    state_nxt = FIN;
                end
            end
            SCAN:    if (hit) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.note  = note_r;
        bus.under = under_r;
        bus.over  = over_r;
        case (state)
            CHECK, NORM, SCAN: bus.busy = 1'b1;
            FIN:               bus.done = 1'b1;
            default:           ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w       <= '0;
            s       <= '0;
            k       <= 4'd11;
            note_r  <= '0;
            under_r <= 1'b0;
            over_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        w       <= {1'b0, bus.adder};
                        s       <= '0;
                        k       <= 4'd11;
                        under_r <= 1'b0;
                        over_r  <= 1'b0;
                    end
                end
                CHECK: begin
                    if (w_ge_2c0) begin
                        over_r <= 1'b1;
                        note_r <= NOTE_MAX[6:0];
                    end
                end
                NORM: begin
                    if (!w_ge_c0) begin
                        if (s_at_max) begin
                            under_r <= 1'b1;
                            note_r  <= '0;
                        end else begin
                            w <= w << 1;
                            s <= s + 4'd1;
                        end
                    end
                end
                SCAN: begin
                    if (hit) begin
                        if (n_over) begin
                            note_r <= NOTE_MAX[6:0];
                            over_r <= 1'b1;
                        end else begin
                            note_r <= n_calc[6:0];
                        end
                    end else begin
                        k <= k - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dds2note_conv.sv
// tb/tb_dds2note_conv.sv - scoreboard bench for dds2note_conv
module tb_dds2note_conv;
    import dds_note_pkg::*;

    typedef struct packed {
        logic [6:0] note;
        logic       under;
        logic       over;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    dds2note_conv_if bus ();

    dds2note_conv #(.OCT_MAX(10), .NOTE_MAX(127)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inc_of(input int n);
        logic [31:0] t;
        t = NOTE_TBL[n % 12];
        return t >> (10 - n / 12);
    endfunction

    function automatic exp_t model(input logic [31:0] x);
        exp_t e;
        e = '0;
        if (x >= inc_of(128)) begin
            e.note = 7'd127;
            e.over = 1'b1;
        end else if (x < inc_of(0)) begin
            e.under = 1'b1;
        end else begin
            for (int n = 127; n >= 0; n--) begin
                if (inc_of(n) <= x) begin
                    e.note = n[6:0];
                    break;
                end
            end
        end
        return e;
    endfunction

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq({tag, "_note"},  {25'd0, bus.note}, {25'd0, e.note});
            check_eq({tag, "_under"}, {31'd0, bus.under}, {31'd0, e.under});
            check_eq({tag, "_over"},  {31'd0, bus.over},  {31'd0, e.over});
        end
    endtask

    task automatic convert(input logic [31:0] x, input string tag);
        int cyc;
        @(negedge clk);
        check_eq({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
        bus.start = 1'b1;
        bus.adder = x;
        sb.push_back(model(x));
        @(negedge clk);
        bus.start = 1'b0;
        bus.adder = $urandom;
        check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_latency_ok"}, {31'd0, (bus.done && cyc <= 28)}, 32'd1);
        compare_result(tag);
    endtask

    initial begin
        int cnt;
        bus.start = 1'b0;
        bus.adder = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",  {31'd0, bus.busy},  32'd0);
        check_eq("rst_done",  {31'd0, bus.done},  32'd0);
        check_eq("rst_note",  {25'd0, bus.note},  32'd0);
        check_eq("rst_under", {31'd0, bus.under}, 32'd0);
        check_eq("rst_over",  {31'd0, bus.over},  32'd0);
        rst = 1'b0;

        convert(NOTE_TBL[9] >> 5, "a4");
        convert(NOTE_TBL[0] >> 10, "note0");
        convert((NOTE_TBL[0] >> 10) - 32'd1, "below0");
        convert(32'd0, "zero");
        convert(NOTE_TBL[7], "note127");
        convert(NOTE_TBL[8], "note128");
        convert({NOTE_TBL[0][30:0], 1'b0}, "two_c0");
        convert(32'hFFFF_FFFF, "max_in");

        for (int n = 0; n < 128; n++) begin
            convert(inc_of(n), $sformatf("exact%0d", n));
            convert(inc_of(n) + 32'd1, $sformatf("plus1_%0d", n));
            convert(inc_of(n + 1) - 32'd1, $sformatf("floor%0d", n));
        end

        // start held high: each accepted start yields exactly one done
        @(negedge clk);
        bus.start = 1'b1;
        bus.adder = {NOTE_TBL[0][30:0], 1'b0};
        for (int i = 0; i < 10; i++) sb.push_back(model(bus.adder));
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                cnt++;
                compare_result($sformatf("held%0d", cnt));
            end
        end
        bus.start = 1'b0;
        check_eq("held_done_count", cnt, 32'd10);
        check_eq("held_sb_drained", sb.size(), 32'd0);
        sb.delete();

        // starts while busy are ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.adder = inc_of(5);
        sb.push_back(model(inc_of(5)));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.adder = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (!bus.done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("busy_ign_done", {31'd0, bus.done}, 32'd1);
        compare_result("busy_ign");
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        check_eq("busy_ign_no_extra", cnt, 32'd0);

        // reset in the middle of normalisation
        convert(NOTE_TBL[7], "pre_rst");
        @(negedge clk);
        bus.start = 1'b1;
        bus.adder = inc_of(3);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy",  {31'd0, bus.busy},  32'd0);
        check_eq("midrst_done",  {31'd0, bus.done},  32'd0);
        check_eq("midrst_note",  {25'd0, bus.note},  32'd0);
        check_eq("midrst_under", {31'd0, bus.under}, 32'd0);
        check_eq("midrst_over",  {31'd0, bus.over},  32'd0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        check_eq("midrst_no_done", cnt, 32'd0);
        convert(inc_of(60) + 32'd5, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
